// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO.
// In-order bundles, bubble on empty, flush drops everything held.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int BP_WIDTH   = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enqValid,
  output logic                         enqReady,
  input  logic [ADDR_WIDTH-1:0]        enqPc,
  input  logic [INSN_WIDTH-1:0]        enqInsn,
  input  logic [BP_WIDTH-1:0]          enqBp,
  output logic                         deqValid,
  input  logic                         deqReady,
  output logic [ADDR_WIDTH-1:0]        deqPc,
  output logic [INSN_WIDTH-1:0]        deqInsn,
  output logic [BP_WIDTH-1:0]          deqBp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almostFull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH = CW'(DEPTH-1);

  logic [ADDR_WIDTH-1:0] pcmem   [DEPTH];
  logic [INSN_WIDTH-1:0] insnmem [DEPTH];
  logic [BP_WIDTH-1:0]   bpmem   [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic          enq;
  logic          deq;

  // Ready depends only on occupancy; no path from deqReady.
  assign enqReady   = (count != FULL);
  assign deqValid   = (count != '0);
  assign almostFull = (count >= HIGH);

  assign enq = enqValid && enqReady && !flush;
  assign deq = deqValid && deqReady && !flush;

  assign deqPc   = deqValid ? pcmem[rptr]   : '0;
  assign deqInsn = deqValid ? insnmem[rptr] : '0;
  assign deqBp   = deqValid ? bpmem[rptr]   : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      pcmem[wptr]   <= enqPc;
      insnmem[wptr] <= enqInsn;
      bpmem[wptr]   <= enqBp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: queue model, negedge monitor.
// Directed plan sequences followed by a randomized phase.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [32:0] bp;
  } ent_t;

  logic        clk = 0;
  logic        rst;
  logic        flush;
  logic        enqValid;
  logic        enqReady;
  logic [31:0] enqPc;
  logic [31:0] enqInsn;
  logic [32:0] enqBp;
  logic        deqValid;
  logic        deqReady;
  logic [31:0] deqPc;
  logic [31:0] deqInsn;
  logic [32:0] deqBp;
  logic [2:0]  count;
  logic        almostFull;

  int checks   = 0;
  int failures = 0;
  ent_t exp[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enqValid(enqValid), .enqReady(enqReady),
    .enqPc(enqPc), .enqInsn(enqInsn), .enqBp(enqBp),
    .deqValid(deqValid), .deqReady(deqReady),
    .deqPc(deqPc), .deqInsn(deqInsn), .deqBp(deqBp),
    .count(count), .almostFull(almostFull)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference model: a plain queue updated from the handshake rules.
  always @(posedge clk) begin
    bit ef;
    bit df;
    int n;
    if (!rst) begin
      exp.delete();
    end else begin
      n  = exp.size();
      ef = enqValid && (n != DEPTH) && !flush;
      df = (n != 0) && deqReady && !flush;
      if (flush) begin
        exp.delete();
      end else begin
        if (df) void'(exp.pop_front());
        if (ef) exp.push_back('{enqPc, enqInsn, enqBp});
      end
    end
  end

  // Monitor: compare every presented output against the model head.
  always @(negedge clk) begin
    if (rst) begin
      chk("count", 64'(count), 64'(exp.size()));
      chk("deqValid", 64'(deqValid), 64'(exp.size() != 0));
      chk("enqReady", 64'(enqReady), 64'(exp.size() != DEPTH));
      chk("almostFull", 64'(almostFull), 64'(exp.size() >= DEPTH-1));
      if (exp.size() != 0) begin
        chk("deqPc", 64'(deqPc), 64'(exp[0].pc));
        chk("deqInsn", 64'(deqInsn), 64'(exp[0].insn));
        chk("deqBp", 64'(deqBp), 64'(exp[0].bp));
      end else begin
        chk("bubble", {deqPc, deqInsn}, 64'd0);
        chk("bubbleBp", 64'(deqBp), 64'd0);
      end
    end
  end

  task automatic step(bit ev, logic [31:0] pc, bit dr, bit fl);
    enqValid = ev;
    enqPc    = pc;
    enqInsn  = $urandom;
    enqBp    = {1'($urandom), 32'($urandom)};
    deqReady = dr;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    flush = 0;
    enqValid = 0;
    deqReady = 0;
    enqPc = '0;
    enqInsn = '0;
    enqBp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_deqValid", 64'(deqValid), 64'd0);
    chk("rst_enqReady", 64'(enqReady), 64'd1);
    rst = 1;
    step(0, 0, 0, 0);

    // Fill to full, then offer a fifth bundle
    for (int i = 0; i < 4; i++) step(1, 32'(4*i), 0, 0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_enqReady", 64'(enqReady), 64'd0);
    step(1, 32'h10, 0, 0);
    chk("full_head", 64'(deqPc), 64'h0);
    step(1, 32'h10, 1, 0);
    chk("full_deq_count", 64'(count), 64'd3);
    step(1, 32'h10, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("drained", 64'(count), 64'd0);

    // Steady stream across pointer wrap
    step(1, 32'h100, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 32'(32'h100 + 4*i), 1, 0);
    chk("stream_count", 64'(count), 64'd1);
    step(0, 0, 1, 0);

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) step(1, 32'(32'h180 + 4*i), 0, 0);
    step(1, 32'h300, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(deqValid), 64'd0);
    step(1, 32'h200, 0, 0);
    chk("post_flush_head", 64'(deqPc), 64'h200);
    step(0, 0, 1, 0);

    // Asynchronous reset between edges
    step(1, 32'h400, 0, 0);
    step(1, 32'h404, 0, 0);
    enqValid = 0;
    #1 rst = 0;
    #1;
    chk("arst_valid", 64'(deqValid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ready", 64'(enqReady), 64'd1);
    exp.delete();
    #1 rst = 1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer on the receiving side of the fetch-to-decode interface.
- Accepts fetched instruction bundles (pc, instruction, branch-prediction info) from the fetch stage.
- Presents them in order to the decode stage with a valid/ready handshake.
- Decouples decode stalls from fetch, and discards all held entries on a pipeline flush from the controller.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_WIDTH, 32, pc width
INSN_WIDTH, 32, instruction width
BP_WIDTH, 33, width of the packed branch-prediction bundle (taken bit plus predicted target)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
flush  input  1  controller flush; discards all entries
enqValid  input  1  fetch stage presents a valid bundle
enqReady  output  1  queue can accept a bundle this cycle
enqPc  input  ADDR_WIDTH  pc of enqueued bundle
enqInsn  input  INSN_WIDTH  instruction of enqueued bundle
enqBp  input  BP_WIDTH  branch-prediction info of enqueued bundle
deqValid  output  1  head entry valid
deqReady  input  1  decode stage consumes head this cycle (not stalled)
deqPc  output  ADDR_WIDTH  head pc
deqInsn  output  INSN_WIDTH  head instruction
deqBp  output  BP_WIDTH  head branch-prediction info
count  output  $clog2(DEPTH+1)  number of occupied entries
almostFull  output  1  count >= DEPTH-1; used by the controller to stall fetch early

Behaviour:
Reset:
- rst low asynchronously clears readPtr, writePtr and count to 0.
- Reset values: deqValid=0, deq* data=0, enqReady=1, almostFull=0.
- Storage contents are don't-care; they are never visible while the queue is empty.

Handshakes:
- Enqueue fires when enqValid && enqReady && !flush.
- Dequeue fires when deqValid && deqReady && !flush.

Outputs:
- enqReady = (count != DEPTH). Purely from state, with no combinational path from deqReady.
- deqValid = (count != 0). deqPc/deqInsn/deqBp show the entry at readPtr when deqValid=1, and all-zero otherwise, so that decode receives a bubble.

Latency:
- An entry written at edge N appears on the deq outputs after edge N. Minimum enq-to-deq latency is one cycle.
- There is no same-cycle bypass from empty.

Pointers and count:
- readPtr and writePtr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- count next value: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.

Full and empty:
- When full, enqReady=0 and an offered bundle is not accepted, even if a dequeue fires in the same cycle.
- When empty, deqReady is ignored.
- A simultaneous enqueue and dequeue at count=1 leaves count at 1, and the new entry becomes head on the next cycle.

Flush:
- On a rising edge with flush=1, readPtr=writePtr=0 and count=0, regardless of enq/deq activity that cycle.
- Bundles offered or consumed in a flush cycle are dropped. The decode stage must treat the flush-cycle head as squashed, since the controller flushes decode too.
- Outputs read empty in the cycle after flush.

Reset mid-operation:
- Asynchronous reset overrides everything immediately; outputs take their reset values without waiting for a clock.

Order:
- Strict FIFO; bundles are never reordered or duplicated.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> deqValid=0, enqReady=1, count=0, deqPc=0, almostFull=0.
- Fill: deqReady=0, enqueue pc 0x00,0x04,0x08,0x0C -> count 1..4, almostFull=1 from count=3, enqReady=0 at count=4. A 5th offer (pc 0x10) is not accepted; deqPc=0x00.
- Full with dequeue and offer: at count=4, deqReady=1 and enqValid=1 (pc 0x10) -> pc 0x00 consumed, 0x10 rejected, count=3. Next cycle 0x10 is accepted and the dequeue order reads 0x04,0x08,0x0C,0x10.
- Wrap and steady stream: enqueue and dequeue every cycle for 10 cycles with pc 0x100+4i -> count stays constant, deqPc sequence is exactly 0x100,0x104,... across pointer wrap, with no gaps.
- Flush: count=3 and flush=1 with enqValid=1, deqReady=1 in the same cycle -> next cycle count=0 and deqValid=0. The flush-cycle enqueued pc never appears; a following enqueue of 0x200 appears as head one cycle later.
- Async reset mid-stream: with count=2, pulse rst low between clock edges -> deqValid=0, count=0, enqReady=1 immediately, before the next rising edge.
